// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
//
// Purpose: FSM state encoding, default frame marker, default memory depth and
//          the instruction-memory word-address width shared by the loader files.
// Ports:   none (package).

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } loaderState_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         IM_DEPTH_DEFAULT  = 1024;

    // Word address width; matches the CPU fetching with PC[11:2].
    localparam int         IM_AW             = 10;

    // True when a received word count exceeds what the memory can hold.
    function automatic logic lenTooLong(input logic [15:0] len, input int depth);
        return ({16'd0, len} > 32'(depth));
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs four little-endian bytes into a 32-bit word
//
// Purpose: counts accepted payload bytes 0..3 and assembles them into a word,
//          first byte in bits [7:0]. The completed word is registered and
//          flagged with a one-cycle wordValid pulse in the cycle after the
//          fourth byte is accepted; word holds its value otherwise.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   clear      in   restart at byte 0 (start of payload)
//   byteValid  in   byteIn is accepted this cycle
//   byteIn     in   payload byte
//   lastByte   out  the next accepted byte completes a word
//   wordValid  out  one-cycle pulse, word is newly assembled
//   word       out  last assembled word

module word_assembler (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteIn,
    output logic        lastByte,
    output logic        wordValid,
    output logic [31:0] word
);

    logic [1:0]  byteIdx;
    logic [23:0] partial;

    assign lastByte = (byteIdx == 2'd3);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byteIdx   <= 2'd0;
            partial   <= 24'd0;
            wordValid <= 1'b0;
            word      <= 32'd0;
        end else begin
            wordValid <= 1'b0;
            if (clear) begin
                byteIdx <= 2'd0;
            end else if (byteValid) begin
                // Two-bit index wraps naturally from 3 back to 0.
                byteIdx <= byteIdx + 2'd1;
                case (byteIdx)
                    2'd0:    partial[7:0]   <= byteIn;
                    2'd1:    partial[15:8]  <= byteIn;
                    2'd2:    partial[23:16] <= byteIn;
                    default: begin
                        word      <= {byteIn, partial};
                        wordValid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream frame loader into instruction memory
//
// Purpose: receives SYNC, LEN_LO, LEN_HI, then LEN little-endian 32-bit words
//          and writes them to consecutive instruction-memory words from 0,
//          holding the CPU in reset while a load is in progress.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte accepted when rx_valid && rx_ready at a rising edge
//   im_we      out  memory write strobe, one cycle per word
//   im_addr    out  memory word address
//   im_wdata   out  memory write data
//   cpu_hold   out  high from LEN_LO through DONE
//   load_done  out  one-cycle pulse at the end of a good frame
//   load_err   out  sticky: frame length exceeded memory depth

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         IM_DEPTH  = IM_DEPTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err
);

    loaderState_t state;
    loaderState_t nextState;

    logic             readyEn;
    logic [7:0]       lenLo;
    logic [15:0]      lenReg;
    logic [15:0]      wordIdx;
    logic [IM_AW-1:0] addrReg;
    logic             loadErr;

    logic             accept;
    logic             dataFire;
    logic             lastByte;
    logic             lastWord;
    logic             syncSeen;
    logic             lenAccept;
    logic             lenBad;
    logic             wordValid;
    logic [31:0]      word;
    logic [15:0]      lenRx;

    // readyEn is low through reset and rises on the first clock after it,
    // so rx_ready is clean during and right after reset release.
    assign rx_ready  = readyEn && (state != ST_DONE);
    assign accept    = rx_valid && rx_ready;
    assign dataFire  = accept && (state == ST_DATA);
    assign syncSeen  = accept && (state == ST_IDLE) && (rx_data == SYNC_BYTE);
    assign lenAccept = accept && (state == ST_LEN_HI);
    assign lenRx     = {rx_data, lenLo};
    assign lenBad    = lenTooLong(lenRx, IM_DEPTH);
    assign lastWord  = (wordIdx == (lenReg - 16'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (syncSeen) begin
                    nextState = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    nextState = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (lenRx == 16'd0) begin
                        nextState = ST_DONE;
                    end else if (lenBad) begin
                        nextState = ST_IDLE;
                    end else begin
                        nextState = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The final write strobe and load_done share the DONE cycle,
                // so no byte past the frame is ever accepted.
                if (dataFire && lastByte && lastWord) begin
                    nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            readyEn <= 1'b0;
            lenLo   <= 8'd0;
            lenReg  <= 16'd0;
            wordIdx <= 16'd0;
            addrReg <= '0;
            loadErr <= 1'b0;
        end else begin
            readyEn <= 1'b1;
            if (accept && (state == ST_LEN_LO)) begin
                lenLo <= rx_data;
            end
            if (lenAccept) begin
                lenReg  <= lenRx;
                wordIdx <= 16'd0;
            end
            // Address is captured with the completing byte so it lines up
            // with the registered word and strobe from the assembler.
            if (dataFire && lastByte) begin
                addrReg <= wordIdx[IM_AW-1:0];
                wordIdx <= wordIdx + 16'd1;
            end
            if (syncSeen) begin
                loadErr <= 1'b0;
            end else if (lenAccept && lenBad) begin
                loadErr <= 1'b1;
            end
        end
    end

    word_assembler u_word_assembler (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (lenAccept),
        .byteValid (dataFire),
        .byteIn    (rx_data),
        .lastByte  (lastByte),
        .wordValid (wordValid),
        .word      (word)
    );

    assign im_we     = wordValid;
    assign im_addr   = addrReg;
    assign im_wdata  = word;
    assign cpu_hold  = (state != ST_IDLE);
    assign load_done = (state == ST_DONE);
    assign load_err  = loadErr;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
`timescale 1ns/1ps

module tb_imem_loader;

    logic        CLK;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t         expQ[$];
    int          expDone = 0;
    logic        expErr  = 1'b0;

    int          doneCnt = 0;
    int          holdCnt = 0;
    logic [9:0]  logAddr[$];
    logic [31:0] logData[$];
    logic        prevWe   = 1'b0;
    logic        prevDone = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Frame-level model: find the marker, read the count, then cut the
    // payload into little-endian words written to addresses 0..LEN-1.
    function automatic void modelFrame(input logic [7:0] fr[$]);
        int i = 0;
        int len;
        int p;
        while (i < fr.size() && fr[i] != 8'hA5) i++;
        if (i + 2 >= fr.size()) return;
        expErr = 1'b0;
        len = int'(fr[i+1]) + 256 * int'(fr[i+2]);
        if (len == 0) begin
            expDone++;
        end else if (len > 1024) begin
            expErr = 1'b1;
        end else begin
            p = i + 3;
            for (int w = 0; w < len; w++) begin
                wr_t e;
                if (p + 3 >= fr.size()) return;
                e.addr = 10'(w);
                e.data = {fr[p+3], fr[p+2], fr[p+1], fr[p]};
                expQ.push_back(e);
                p += 4;
            end
            expDone++;
        end
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            prevWe   <= 1'b0;
            prevDone <= 1'b0;
        end else begin
            if (im_we) begin
                check("we_not_back_to_back", {31'd0, prevWe}, 32'd0);
                check("write_expected", {31'd0, expQ.size() > 0}, 32'd1);
                if (expQ.size() > 0) begin
                    wr_t e;
                    e = expQ.pop_front();
                    check("write_addr", {22'd0, im_addr}, {22'd0, e.addr});
                    check("write_data", im_wdata, e.data);
                end
                logAddr.push_back(im_addr);
                logData.push_back(im_wdata);
            end
            if (load_done) begin
                doneCnt++;
                check("done_rx_ready_low", {31'd0, rx_ready}, 32'd0);
                check("done_hold_high", {31'd0, cpu_hold}, 32'd1);
            end
            if (prevDone) begin
                check("hold_release_after_done", {31'd0, cpu_hold}, 32'd0);
            end
            if (cpu_hold) holdCnt++;
            prevWe   <= im_we;
            prevDone <= load_done;
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        for (int g = 0; g < gap; g++) @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            acc = rx_ready;
            @(negedge CLK);
            n++;
        end
        if (!acc) check("rx_accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] fr[$], input int maxGap);
        foreach (fr[i]) begin
            int gap;
            gap = (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap));
            sendByte(fr[i], gap);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic endChecks();
        check("pending_writes", expQ.size(), 32'd0);
        check("done_count", doneCnt, expDone);
        check("load_err", {31'd0, load_err}, {31'd0, expErr});
    endtask

    task automatic checkAllZero();
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", {22'd0, im_addr}, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];

        RST      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        settle(3);
        checkAllZero();
        RST = 1'b1;
        check("rx_ready_low_at_release", {31'd0, rx_ready}, 32'd0);
        settle(1);
        check("rx_ready_after_release", {31'd0, rx_ready}, 32'd1);
        settle(2);

        // Two-word frame.
        logAddr.delete();
        logData.delete();
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        modelFrame(fr);
        check("model_pin_word0", expQ[0].data, 32'h12345678);
        check("model_pin_word1", expQ[1].data, 32'hDEADBEEF);
        sendFrame(fr, 0);
        settle(5);
        endChecks();
        check("t1_write_count", logData.size(), 32'd2);
        if (logData.size() == 2) begin
            check("t1_word0", logData[0], 32'h12345678);
            check("t1_addr1", {22'd0, logAddr[1]}, 32'd1);
            check("t1_word1", logData[1], 32'hDEADBEEF);
        end

        // Leading junk, then empty frame.
        logData.delete();
        logAddr.delete();
        holdCnt = 0;
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        modelFrame(fr);
        sendFrame(fr, 0);
        settle(5);
        endChecks();
        check("t2_no_writes", logData.size(), 32'd0);
        check("t2_hold_cycles", holdCnt, 32'd3);

        // Oversize length, then recovery on the next marker.
        fr = '{8'hA5, 8'h01, 8'h04};
        modelFrame(fr);
        sendFrame(fr, 0);
        settle(5);
        endChecks();
        check("t3_err_set", {31'd0, load_err}, 32'd1);
        check("t3_back_in_idle_hold", {31'd0, cpu_hold}, 32'd0);
        check("t3_back_in_idle_ready", {31'd0, rx_ready}, 32'd1);
        check("t3_no_writes", logData.size(), 32'd0);
        fr = '{8'hA5, 8'h00, 8'h00};
        modelFrame(fr);
        sendByte(8'hA5, 0);
        check("t3_err_cleared", {31'd0, load_err}, 32'd0);
        check("t3_hold_in_len_lo", {31'd0, cpu_hold}, 32'd1);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        settle(5);
        endChecks();

        // Marker value as payload, irregular gaps.
        logData.delete();
        logAddr.delete();
        fr = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        modelFrame(fr);
        sendFrame(fr, 4);
        settle(5);
        endChecks();
        check("t4_write_count", logData.size(), 32'd1);
        if (logData.size() == 1) begin
            check("t4_word", logData[0], 32'hA5A5A5A5);
            check("t4_addr", {22'd0, logAddr[0]}, 32'd0);
        end

        // Reset after the second payload byte.
        logData.delete();
        logAddr.delete();
        sendByte(8'hA5, 0);
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        RST = 1'b0;
        settle(2);
        checkAllZero();
        RST = 1'b1;
        settle(2);
        fr = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        modelFrame(fr);
        sendFrame(fr, 1);
        settle(5);
        endChecks();
        check("t5_write_count", logData.size(), 32'd1);
        if (logData.size() == 1) begin
            check("t5_word", logData[0], 32'h11223344);
            check("t5_addr", {22'd0, logAddr[0]}, 32'd0);
        end

        // Full-depth load.
        logData.delete();
        logAddr.delete();
        fr = '{8'hA5, 8'h00, 8'h04};
        for (int w = 0; w < 1024; w++) begin
            logic [31:0] v;
            v = 32'h1000_0000 + 32'(w);
            fr.push_back(v[7:0]);
            fr.push_back(v[15:8]);
            fr.push_back(v[23:16]);
            fr.push_back(v[31:24]);
        end
        modelFrame(fr);
        check("model_pin_full_count", expQ.size(), 32'd1024);
        sendFrame(fr, 0);
        settle(5);
        endChecks();
        check("t6_write_count", logData.size(), 32'd1024);
        if (logData.size() == 1024) begin
            check("t6_last_addr", {22'd0, logAddr[1023]}, 32'd1023);
            check("t6_last_word", logData[1023], 32'h100003FF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter IM_DEPTH, default 1024, instruction memory depth in words.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  incoming byte.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at a rising edge.
REQ-008 im_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 im_addr  output  10  instruction memory word address (matches the CPU's PC[11:2] word indexing).
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-012 load_done  output  1  one-cycle pulse at successful end of a frame.
REQ-013 load_err  output  1  sticky error flag.

Function
REQ-014 Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count, little-endian), then LEN words of 4 bytes each, little-endian (first byte -> im_wdata[7:0]).
REQ-015 FSM states IDLE, LEN_LO, LEN_HI, DATA, DONE; reset state IDLE.
REQ-016 IDLE: accepted byte == SYNC_BYTE -> LEN_LO and load_err cleared; any other byte discarded, state unchanged.
REQ-017 LEN_LO -> LEN_HI on accepted byte; LEN_HI -> DATA on accepted byte, word index and byte index reset to 0.
REQ-018 LEN == 0 -> DONE directly from LEN_HI; no writes.
REQ-019 LEN > IM_DEPTH -> load_err set, return to IDLE, no writes.
REQ-020 rx_ready = 1 in IDLE, LEN_LO, LEN_HI, DATA; 0 in DONE.
REQ-021 DATA: byte index counts 0..3 and wraps; on the 4th accepted byte of a word, im_we = 1 in the next cycle with im_addr = word index and im_wdata = the assembled word.
REQ-022 Word index increments after each write; after word LEN-1 is written, the next state is DONE.
REQ-023 im_addr and im_wdata hold their last values when im_we = 0; im_we is never high for two consecutive cycles.
REQ-024 DONE lasts exactly one cycle with load_done = 1, then -> IDLE.
REQ-025 cpu_hold = 1 in LEN_LO, LEN_HI, DATA and DONE; 0 in IDLE, so the CPU is released in the cycle after load_done.
REQ-026 rx_valid gaps of any length are tolerated; no timeout.
REQ-027 A SYNC_BYTE value received inside LEN or DATA is treated as payload, not as a restart.

Reset
REQ-028 While RST = 0: state IDLE, all counters 0, rx_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 0, load_done 0, load_err 0.
REQ-029 Reset mid-frame discards any partial word and aborts the frame; already-written words remain in memory.
REQ-030 rx_ready rises in the first cycle after RST deasserts.

Structure
REQ-031 Package imem_loader_pkg holds the FSM state enum, SYNC_BYTE default, IM_DEPTH and IM_AW = 10.
REQ-032 One sub-module, word_assembler, contains the byte-index counter and 32-bit shift/assemble register and outputs a word_valid pulse; the FSM and address counter live in imem_loader.

Verification
REQ-033 Send A5 02 00 78 56 34 12 EF BE AD DE -> writes (0, 32'h12345678) then (1, 32'hDEADBEEF); load_done pulses once; cpu_hold falls the cycle after.
REQ-034 Send 00 FF A5 00 00 -> the first two bytes are ignored; load_done pulses; no im_we; cpu_hold high only during LEN_LO through DONE.
REQ-035 Send A5 01 04 (LEN = 1025) -> load_err = 1; no im_we; FSM back in IDLE; the next A5 clears load_err.
REQ-036 Send A5 01 00 A5 A5 A5 A5 with random rx_valid gaps -> single write (0, 32'hA5A5A5A5).
REQ-037 Assert RST after the 2nd data byte of a frame -> all outputs 0; a fresh frame then writes from address 0 correctly.
REQ-038 Full 1024-word load of incrementing data -> 1024 writes with im_addr 0..1023, no gaps or duplicate addresses, load_done once.
